ram_write_arbiter: RTL and testbench
====================================

Name: ram_write_arbiter

Overview:
- Owns the write port of the single-clock-domain dual-port video frame/line RAM.
- Shares that port between two write clients, A and B, using valid/ready handshakes and round-robin arbitration.
- Provides a built-in clear engine that fills every RAM address with a programmable value.
- The read port is untouched; scanout continues to drive it directly.

Parameters:
- ADDR_WIDTH, 8, RAM address width; RAM depth N = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clk  in  1  single clock; also drives the RAM wclk.
- rst  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle pulse; starts a full-RAM fill.
- clear_value  in  DATA_WIDTH  fill word; sampled on the accepted clear_start.
- clear_busy  out  1  high while the fill is in progress.
- a_valid  in  1  client A has a write pending.
- a_addr  in  ADDR_WIDTH  client A write address.
- a_data  in  DATA_WIDTH  client A write data.
- a_ready  out  1  client A transfer accepted this cycle.
- b_valid  in  1  client B has a write pending.
- b_addr  in  ADDR_WIDTH  client B write address.
- b_data  in  DATA_WIDTH  client B write data.
- b_ready  out  1  client B transfer accepted this cycle.
- ram_waddr  out  ADDR_WIDTH  to RAM waddr.
- ram_data  out  DATA_WIDTH  to RAM data_in.
- ram_write_en  out  1  to RAM write_en.

Behaviour:
- Reset values:
  - State IDLE.
  - ram_write_en=0, ram_waddr=0, ram_data=0.
  - clear_busy=0.
  - Fill counter 0.
  - last_grant=B, so A wins the first contention.
- Handshake:
  - A transfer occurs on a cycle where x_valid && x_ready.
  - a_ready and b_ready are combinational from registered state and the current valids/clear_start.
  - At most one ready is high per cycle.
  - A client holds valid, addr and data stable until its transfer.
- IDLE arbitration, applied when clear_start=0:
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the client != last_grant.
  - On any transfer, last_grant becomes the granted client.
- Write latency:
  - A transfer in cycle t gives ram_write_en=1 in cycle t+1, with ram_waddr/ram_data equal to the transferred addr/data.
  - Otherwise ram_write_en=0 in t+1.
  - One write per cycle sustained; back-to-back transfers allowed.
- Clear:
  - clear_start=1 while in IDLE is accepted and both readies are 0 that cycle, so clear beats pending clients.
  - Call the acceptance cycle c. From the next cycle the block is in state CLEAR.
  - clear_busy=1 for cycles c+1 through c+N.
  - ram_write_en=1 in cycle c+1+k with ram_waddr=k and ram_data=clear_value (latched at c), for k=0..N-1.
  - After address N-1 the counter wraps to 0 and no extra write is issued.
  - In cycle c+N+1: state IDLE, clear_busy=0, readies may assert.
- During CLEAR:
  - a_ready=b_ready=0.
  - Client valids are held off, not dropped.
  - clear_start is ignored, with no restart and no queuing.
  - last_grant is unchanged.
- Reset mid-clear:
  - Next cycle: IDLE, clear_busy=0, ram_write_en=0, counter 0.
  - Partial fill is left in RAM.
- Reset mid-handshake: any write scheduled for the next cycle is suppressed (ram_write_en=0).
- Width rules:
  - The counter is ADDR_WIDTH+1 bits, or ADDR_WIDTH bits plus a done flag.
  - N-1 is the terminal address.
  - No arithmetic on data.

Test Plan:
- Reset, then a_valid=1 a_addr=0x10 a_data=0xAA for 1 cycle -> a_ready=1 same cycle; next cycle ram_write_en=1, waddr=0x10, data=0xAA; following cycle ram_write_en=0.
- a_valid and b_valid both held high for 4 cycles (A: addr 1..4, B: addr 0x81..0x84) -> grants A,B,A,B; RAM writes 0x01,0x81,0x02,0x82 on consecutive cycles.
- clear_start with clear_value=0x5C, ADDR_WIDTH=8 -> clear_busy high exactly 256 cycles; 256 writes addr 0..255 of 0x5C; readback via the RAM read port all 0x5C.
- clear_start coincident with a_valid=1, and a second clear_start pulse mid-fill -> a_ready stays 0 until clear_busy falls; exactly 256 fill writes; the held A write lands one cycle after a_ready.
- Reset asserted at fill address 100 -> next cycle clear_busy=0, ram_write_en=0; a new clear_start restarts at address 0.
- Only b_valid pulsing every cycle for 8 cycles -> b_ready every cycle, 8 consecutive RAM writes; a subsequent A/B contention grants A first.

Source files
------------

// File: rtl/ram_write_arbiter_if.sv
// rtl/ram_write_arbiter_if.sv - client handshakes, clear control and RAM write bus of the write arbiter
interface ram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  clear_start;
  logic [DATA_WIDTH-1:0] clear_value;
  logic                  clear_busy;

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_write_en;

  // Clients, clear controller and RAM side of the bus
  modport master (
    output clear_start, clear_value,
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  clear_busy, a_ready, b_ready,
    input  ram_waddr, ram_data, ram_write_en
  );

  // Arbiter side of the bus
  modport slave (
    input  clear_start, clear_value,
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output clear_busy, a_ready, b_ready,
    output ram_waddr, ram_data, ram_write_en
  );
endinterface

// File: rtl/ram_write_arbiter.sv
// rtl/ram_write_arbiter.sv - round-robin two-client RAM write arbiter with full-RAM clear engine
module ram_write_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_write_arbiter_if.slave   bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  // High when B received the most recent grant; reset to B so A wins first contention.
  logic                  last_b_q, last_b_d;
  // Fill address; the CLEAR state itself acts as the "not done" flag.
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  // Client write staged for the following cycle.
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  a_ready, b_ready;
  logic                  grant_a, grant_b;
  logic                  busy;

  // Arbitration, clear acceptance and fill sequencing
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          // Clear wins over any pending client; clients simply keep waiting.
          state_d = ST_CLEAR;
          cnt_d   = '0;
          fill_d  = bus.clear_value;
        end else begin
          grant_a = bus.a_valid && (!bus.b_valid || last_b_q);
          grant_b = bus.b_valid && !grant_a;
          if (grant_a) begin
            a_ready  = 1'b1;
            we_d     = 1'b1;
            waddr_d  = bus.a_addr;
            wdata_d  = bus.a_data;
            last_b_d = 1'b0;
          end else if (grant_b) begin
            b_ready  = 1'b1;
            we_d     = 1'b1;
            waddr_d  = bus.b_addr;
            wdata_d  = bus.b_data;
            last_b_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        // One fill write per cycle; leave after the terminal address, counter wraps to 0.
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and staged-write registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      fill_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // RAM write port: fill engine owns it while busy, otherwise the staged client write
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  assign bus.clear_busy   = busy;
  assign bus.a_ready      = a_ready;
  assign bus.b_ready      = b_ready;
  assign bus.ram_write_en = busy | we_q;
  assign bus.ram_waddr    = busy ? cnt_q  : waddr_q;
  assign bus.ram_data     = busy ? fill_q : wdata_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb/tb_ram_write_arbiter.sv - directed self-checking bench for ram_write_arbiter
module tb_ram_write_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int fill_writes = 0;
  int fills_before;
  int bad;
  int a_idx;
  int b_idx;

  logic [DW-1:0] mem [N];

  ram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM behind the write port plus a count of fill writes
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_waddr] <= bus.ram_data;
    if (bus.ram_write_en && bus.clear_busy) fill_writes <= fill_writes + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]    exp_a_gnt   = 4'b0101;
  logic [7:0]    exp_waddr_c [4] = '{8'h01, 8'h81, 8'h02, 8'h82};
  logic [7:0]    exp_wdata_c [4] = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};

  initial begin
    bus.clear_start = 1'b0;
    bus.clear_value = '0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

    // Reset state
    tick(); tick(); #1;
    check("rst_we",    32'(bus.ram_write_en), 0);
    check("rst_waddr", 32'(bus.ram_waddr), 0);
    check("rst_data",  32'(bus.ram_data), 0);
    check("rst_busy",  32'(bus.clear_busy), 0);
    rst = 1'b0;

    // Single A write
    tick();
    bus.a_valid = 1'b1; bus.a_addr = 8'h10; bus.a_data = 8'hAA; #1;
    check("t1_a_ready", 32'(bus.a_ready), 1);
    check("t1_b_ready", 32'(bus.b_ready), 0);
    tick();
    bus.a_valid = 1'b0; #1;
    check("t1_we",    32'(bus.ram_write_en), 1);
    check("t1_waddr", 32'(bus.ram_waddr), 32'h10);
    check("t1_data",  32'(bus.ram_data), 32'hAA);
    tick(); #1;
    check("t1_we_off", 32'(bus.ram_write_en), 0);

    // Contention after reset: A,B,A,B
    rst = 1'b1; tick(); rst = 1'b0;
    a_idx = 1; b_idx = 1;
    for (int i = 0; i < 4; i++) begin
      bus.a_valid = 1'b1; bus.a_addr = 8'(a_idx); bus.a_data = 8'(8'hA0 + a_idx);
      bus.b_valid = 1'b1; bus.b_addr = 8'(8'h80 + b_idx); bus.b_data = 8'(8'hB0 + b_idx);
      #1;
      check("rr_a_ready", 32'(bus.a_ready), 32'(exp_a_gnt[i]));
      check("rr_b_ready", 32'(bus.b_ready), 32'(!exp_a_gnt[i]));
      if (i > 0) begin
        check("rr_we",    32'(bus.ram_write_en), 1);
        check("rr_waddr", 32'(bus.ram_waddr), 32'(exp_waddr_c[i-1]));
        check("rr_data",  32'(bus.ram_data), 32'(exp_wdata_c[i-1]));
      end
      if (bus.a_ready) a_idx++;
      else if (bus.b_ready) b_idx++;
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; #1;
    check("rr_we_last",    32'(bus.ram_write_en), 1);
    check("rr_waddr_last", 32'(bus.ram_waddr), 32'h82);
    check("rr_data_last",  32'(bus.ram_data), 32'hB2);
    tick(); #1;
    check("rr_we_off", 32'(bus.ram_write_en), 0);

    // Clear with a pending A write and a second clear_start mid-fill
    bus.clear_start = 1'b1; bus.clear_value = 8'h5C;
    bus.a_valid = 1'b1; bus.a_addr = 8'h33; bus.a_data = 8'h77; #1;
    check("clr_acc_a_ready", 32'(bus.a_ready), 0);
    check("clr_acc_b_ready", 32'(bus.b_ready), 0);
    check("clr_acc_busy",    32'(bus.clear_busy), 0);
    fills_before = fill_writes;
    tick();
    bus.clear_start = 1'b0; bus.clear_value = 8'h00;
    for (int k = 0; k < N; k++) begin
      bus.clear_start = (k == 100); #1;
      check("clr_busy",    32'(bus.clear_busy), 1);
      check("clr_we",      32'(bus.ram_write_en), 1);
      check("clr_waddr",   32'(bus.ram_waddr), 32'(k));
      check("clr_data",    32'(bus.ram_data), 32'h5C);
      check("clr_a_ready", 32'(bus.a_ready), 0);
      tick();
    end
    bus.clear_start = 1'b0; #1;
    check("clr_end_busy",    32'(bus.clear_busy), 0);
    check("clr_end_we",      32'(bus.ram_write_en), 0);
    check("clr_end_a_ready", 32'(bus.a_ready), 1);
    tick();
    bus.a_valid = 1'b0; #1;
    check("held_a_we",    32'(bus.ram_write_en), 1);
    check("held_a_waddr", 32'(bus.ram_waddr), 32'h33);
    check("held_a_data",  32'(bus.ram_data), 32'h77);
    check("clr_fill_count", 32'(fill_writes - fills_before), 32'(N));
    tick();
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (k == 8'h33) begin
        if (mem[k] !== 8'h77) bad++;
      end else if (mem[k] !== 8'h5C) begin
        bad++;
      end
    end
    check("clr_readback_bad", 32'(bad), 0);

    // Reset at fill address 100, then restart
    bus.clear_start = 1'b1; bus.clear_value = 8'h11; #1;
    tick();
    bus.clear_start = 1'b0;
    repeat (100) tick();
    #1;
    check("rc_waddr100", 32'(bus.ram_waddr), 32'd100);
    check("rc_busy100",  32'(bus.clear_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rc_busy_after_rst", 32'(bus.clear_busy), 0);
    check("rc_we_after_rst",   32'(bus.ram_write_en), 0);
    check("rc_partial_lo",     32'(mem[50]), 32'h11);
    check("rc_partial_hi",     32'(mem[150]), 32'h5C);
    bus.clear_start = 1'b1; bus.clear_value = 8'h22; #1;
    tick();
    bus.clear_start = 1'b0; #1;
    check("rc_restart_we",    32'(bus.ram_write_en), 1);
    check("rc_restart_waddr", 32'(bus.ram_waddr), 0);
    check("rc_restart_data",  32'(bus.ram_data), 32'h22);
    check("rc_restart_busy",  32'(bus.clear_busy), 1);
    repeat (N - 1) tick();
    #1;
    check("rc_last_waddr", 32'(bus.ram_waddr), 32'hFF);
    check("rc_last_busy",  32'(bus.clear_busy), 1);
    tick(); #1;
    check("rc_done_busy", 32'(bus.clear_busy), 0);
    check("rc_done_we",   32'(bus.ram_write_en), 0);
    bad = 0;
    for (int k = 0; k < N; k++) if (mem[k] !== 8'h22) bad++;
    check("rc_readback_bad", 32'(bad), 0);

    // B streaming every cycle, then contention grants A first
    for (int i = 0; i < 8; i++) begin
      bus.b_valid = 1'b1; bus.b_addr = 8'(8'h40 + i); bus.b_data = 8'(8'hC0 + i); #1;
      check("bs_b_ready", 32'(bus.b_ready), 1);
      check("bs_a_ready", 32'(bus.a_ready), 0);
      if (i > 0) begin
        check("bs_we",    32'(bus.ram_write_en), 1);
        check("bs_waddr", 32'(bus.ram_waddr), 32'(8'h40 + i - 1));
      end
      tick();
    end
    bus.b_valid = 1'b0; #1;
    check("bs_we_last",    32'(bus.ram_write_en), 1);
    check("bs_waddr_last", 32'(bus.ram_waddr), 32'h47);
    check("bs_data_last",  32'(bus.ram_data), 32'hC7);
    bus.a_valid = 1'b1; bus.a_addr = 8'h50; bus.a_data = 8'hD0;
    bus.b_valid = 1'b1; bus.b_addr = 8'h60; bus.b_data = 8'hE0; #1;
    check("ct_a_ready", 32'(bus.a_ready), 1);
    check("ct_b_ready", 32'(bus.b_ready), 0);
    tick();
    bus.a_valid = 1'b0; #1;
    check("ct_b_ready_next", 32'(bus.b_ready), 1);
    check("ct_waddr_a",      32'(bus.ram_waddr), 32'h50);
    check("ct_data_a",       32'(bus.ram_data), 32'hD0);
    tick();
    bus.b_valid = 1'b0; #1;
    check("ct_we_b",    32'(bus.ram_write_en), 1);
    check("ct_waddr_b", 32'(bus.ram_waddr), 32'h60);
    check("ct_data_b",  32'(bus.ram_data), 32'hE0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
